machine_timer: RTL and testbench

- Machine timer source that feeds the trap unit's isMachineTimerInterrupt input (mip.MTIP / mcause 7).
- Holds a 64-bit mtime counter with programmable prescaler and a 64-bit mtimecmp, all accessed through the core CSR bus in the custom machine R/W range.
- Supports one-shot compare mode and periodic auto-wrap mode with a sticky pending flag.

---
 rtl/machine_timer.sv | 154 +++++++++++++++
 tb/tb_machine_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, one-shot/periodic MTIP.
// Define MACHINE_TIMER_SNAPSHOT_EN to latch mtime[63:32] on a low-word read.
module machine_timer #(
  parameter logic [11:0] BASE_ADDRESS   = 12'h7C0,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csrWriteEnable,
  input  logic        csrReadEnable,
  input  logic [11:0] csrAddress,
  input  logic [31:0] csrWriteData,
  output logic [31:0] csrReadData,
  output logic        requestOutput,
  output logic        isMachineTimerInterrupt
);

  localparam int PW = PRESCALE_WIDTH;

  logic [11:0]   off;
  logic          hit;
  logic          wr_ctrl, wr_lo, wr_hi;
  logic          wr_clo, wr_chi;
  logic          tick, ge, wrap;

  logic          en_q, en_d;
  logic          per_q, per_d;
  logic          ie_q, ie_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic          ge_q, ge_d;
  logic          irq_q, irq_d;
  logic [31:0]   hi_rd;
  logic [31:0]   ctrl_rd;
  logic          unused_wd;

  assign off = csrAddress - BASE_ADDRESS;
  assign hit = (csrAddress >= BASE_ADDRESS) && (off <= 12'd4);

  assign wr_ctrl = csrWriteEnable && hit && (off == 12'd0);
  assign wr_lo   = csrWriteEnable && hit && (off == 12'd1);
  assign wr_hi   = csrWriteEnable && hit && (off == 12'd2);
  assign wr_clo  = csrWriteEnable && hit && (off == 12'd3);
  assign wr_chi  = csrWriteEnable && hit && (off == 12'd4);

  assign unused_wd = ^{csrWriteData[30:8+PW], csrWriteData[7:3]};

`ifdef MACHINE_TIMER_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (csrReadEnable && hit && (off == 12'd1))
      snap_d = mtime_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  assign hi_rd = snap_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    pre_d   = pre_q;
    cmp_d   = cmp_q;
    mtime_d = mtime_q;
    tick    = en_q && (cnt_q == pre_q);
    ge      = mtime_q >= cmp_q;
    wrap    = tick && per_q && ge && !wr_lo && !wr_hi;

    if (!en_q || tick) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;

    if (wr_ctrl) begin
      en_d  = csrWriteData[0];
      per_d = csrWriteData[1];
      ie_d  = csrWriteData[2];
      pre_d = csrWriteData[8 +: PW];
      cnt_d = '0;
    end

    // A software write to either mtime half overrides the tick.
    if (wr_lo)      mtime_d[31:0]  = csrWriteData;
    else if (wr_hi) mtime_d[63:32] = csrWriteData;
    else if (tick)  mtime_d = wrap ? 64'd0 : mtime_q + 64'd1;

    if (wr_clo) cmp_d[31:0]  = csrWriteData;
    if (wr_chi) cmp_d[63:32] = csrWriteData;

    if (wrap)                            pend_d = 1'b1;
    else if (wr_ctrl && csrWriteData[31]) pend_d = 1'b0;
    else                                 pend_d = pend_q;

    ge_d  = ge;
    irq_d = ie_q && (per_q ? pend_q : ge_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      ge_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      ge_q    <= ge_d;
      irq_q   <= irq_d;
    end
  end

  assign ctrl_rd = {pend_q, {(23-PW){1'b0}}, pre_q,
                    5'b0, ie_q, per_q, en_q};

  always_comb begin
    csrReadData = '0;
    if (requestOutput) begin
      unique case (1'b1)
        off == 12'd0: csrReadData = ctrl_rd;
        off == 12'd1: csrReadData = mtime_q[31:0];
        off == 12'd2: csrReadData = hi_rd;
        off == 12'd3: csrReadData = cmp_q[31:0];
        off == 12'd4: csrReadData = cmp_q[63:32];
        default:      csrReadData = '0;
      endcase
    end
  end

  assign requestOutput           = csrReadEnable && hit;
  assign isMachineTimerInterrupt = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: reset map, one-shot, prescale,
// periodic wrap with W1C, carry, write collision, reset override, snapshot.
module tb_machine_timer;

  localparam logic [11:0] BASE = 12'h7C0;

  logic        clk;
  logic        rst;
  logic        csrWriteEnable;
  logic        csrReadEnable;
  logic [11:0] csrAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        requestOutput;
  logic        isMachineTimerInterrupt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  machine_timer #(
    .BASE_ADDRESS  (BASE),
    .PRESCALE_WIDTH(8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .csrWriteEnable         (csrWriteEnable),
    .csrReadEnable          (csrReadEnable),
    .csrAddress             (csrAddress),
    .csrWriteData           (csrWriteData),
    .csrReadData            (csrReadData),
    .requestOutput          (requestOutput),
    .isMachineTimerInterrupt(isMachineTimerInterrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    csrWriteEnable = 1'b0;
    csrReadEnable  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csrWriteEnable = 1'b1;
    csrAddress     = a;
    csrWriteData   = d;
    @(posedge clk);
    #1;
    csrWriteEnable = 1'b0;
  endtask

  // Combinational read, no clock edge crossed.
  task automatic peek(input logic [11:0] a, input logic [31:0] exp,
                      input logic req, input string tag);
    exp_q.push_back(exp);
    csrReadEnable = 1'b1;
    csrAddress    = a;
    #1;
    chk({tag, "_req"}, {31'b0, requestOutput}, {31'b0, req});
    chk(tag, csrReadData, exp_q.pop_front());
    csrReadEnable = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, isMachineTimerInterrupt}, {31'b0, exp});
  endtask

  initial begin
    logic [31:0] hi_exp;
    csrAddress   = '0;
    csrWriteData = '0;
    do_reset();

    // reset map
    peek(BASE + 12'd0, 32'h0, 1'b1, "rst_ctrl");
    peek(BASE + 12'd1, 32'h0, 1'b1, "rst_mlo");
    peek(BASE + 12'd2, 32'h0, 1'b1, "rst_mhi");
    peek(BASE + 12'd3, 32'hFFFF_FFFF, 1'b1, "rst_clo");
    peek(BASE + 12'd4, 32'hFFFF_FFFF, 1'b1, "rst_chi");
    peek(BASE + 12'd5, 32'h0, 1'b0, "miss_hi");
    peek(BASE - 12'd1, 32'h0, 1'b0, "miss_lo");
    chk_irq("rst_irq", 1'b0);

    // one-shot, prescale 0, mtimecmp=10
    csr_wr(BASE + 12'd3, 32'd10);
    csr_wr(BASE + 12'd4, 32'd0);
    csr_wr(BASE + 12'd0, 32'h0000_0005);
    peek(BASE + 12'd1, 32'd0, 1'b1, "os_m0");
    for (int k = 1; k <= 13; k++) begin
      tick();
      peek(BASE + 12'd1, k, 1'b1, $sformatf("os_m%0d", k));
      chk_irq($sformatf("os_irq%0d", k), k >= 12);
    end

    // prescale 3
    do_reset();
    csr_wr(BASE + 12'd0, 32'h0000_0301);
    repeat (39) @(posedge clk);
    #1;
    peek(BASE + 12'd1, 32'd9, 1'b1, "ps_m39");
    tick();
    peek(BASE + 12'd1, 32'd10, 1'b1, "ps_m40");

    // periodic, mtimecmp=4
    do_reset();
    csr_wr(BASE + 12'd3, 32'd4);
    csr_wr(BASE + 12'd4, 32'd0);
    csr_wr(BASE + 12'd0, 32'h0000_0007);
    for (int k = 1; k <= 7; k++) begin
      tick();
      peek(BASE + 12'd1, (k <= 4) ? k : k - 5, 1'b1,
           $sformatf("pr_m%0d", k));
      peek(BASE + 12'd0, (k >= 5) ? 32'h8000_0007 : 32'h7, 1'b1,
           $sformatf("pr_c%0d", k));
      chk_irq($sformatf("pr_irq%0d", k), k >= 6);
    end
    csr_wr(BASE + 12'd0, 32'h8000_0007);
    peek(BASE + 12'd0, 32'h7, 1'b1, "w1c_ctrl");
    peek(BASE + 12'd1, 32'd3, 1'b1, "w1c_m");
    chk_irq("w1c_irq0", 1'b1);
    tick();
    chk_irq("w1c_irq1", 1'b0);
    peek(BASE + 12'd1, 32'd4, 1'b1, "w1c_m4");
    tick();
    peek(BASE + 12'd0, 32'h8000_0007, 1'b1, "rewrap_c");
    peek(BASE + 12'd1, 32'd0, 1'b1, "rewrap_m");
    chk_irq("rewrap_irq0", 1'b0);
    tick();
    chk_irq("rewrap_irq1", 1'b1);

    // carry and write collision
    do_reset();
    csr_wr(BASE + 12'd1, 32'hFFFF_FFFF);
    csr_wr(BASE + 12'd2, 32'h0);
    csr_wr(BASE + 12'd0, 32'h0000_0001);
    peek(BASE + 12'd1, 32'hFFFF_FFFF, 1'b1, "cy_lo0");
    peek(BASE + 12'd2, 32'h0, 1'b1, "cy_hi0");
    tick();
    peek(BASE + 12'd1, 32'h0, 1'b1, "cy_lo1");
    peek(BASE + 12'd2, 32'h1, 1'b1, "cy_hi1");
    csr_wr(BASE + 12'd1, 32'h55);
    peek(BASE + 12'd1, 32'h55, 1'b1, "col_lo");
    peek(BASE + 12'd2, 32'h1, 1'b1, "col_hi");
    tick();
    peek(BASE + 12'd1, 32'h56, 1'b1, "col_next");

    // reset beats a simultaneous write
    @(negedge clk);
    rst            = 1'b1;
    csrWriteEnable = 1'b1;
    csrAddress     = BASE + 12'd1;
    csrWriteData   = 32'h1234;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    csrWriteEnable = 1'b0;
    peek(BASE + 12'd1, 32'h0, 1'b1, "rw_mlo");
    peek(BASE + 12'd0, 32'h0, 1'b1, "rw_ctrl");
    peek(BASE + 12'd3, 32'hFFFF_FFFF, 1'b1, "rw_clo");

    // low-then-high read across a carry
    do_reset();
    csr_wr(BASE + 12'd1, 32'hFFFF_FFFF);
    csr_wr(BASE + 12'd2, 32'h0);
    csr_wr(BASE + 12'd0, 32'h0000_0101);
    exp_q.push_back(32'hFFFF_FFFF);
    csrReadEnable = 1'b1;
    csrAddress    = BASE + 12'd1;
    #1;
    chk("snap_lo", csrReadData, exp_q.pop_front());
    tick();
    csrReadEnable = 1'b0;
    tick();
`ifdef MACHINE_TIMER_SNAPSHOT_EN
    hi_exp = 32'h0;
`else
    hi_exp = 32'h1;
`endif
    peek(BASE + 12'd2, hi_exp, 1'b1, "snap_hi");
    peek(BASE + 12'd1, 32'h0, 1'b1, "snap_lo_after");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
